// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, constants and types for the PWM peripheral
package pwm_pkg;

   localparam int PWM_BITS = 8;
   localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;
   localparam int N_OUT = 16;

   typedef logic [N_OUT-1:0] out_vec_t;

   // Full-scale duty means "never low", so the period wrap cannot leave a one-tick gap.
   function automatic logic pwm_level(input logic [PWM_BITS-1:0] cnt,
                                      input logic [PWM_BITS-1:0] duty);
      return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - divides clk down to the PWM tick rate
module pwm_prescaler #(
   parameter int PRESCALE = 13
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

   logic [W-1:0] pre_cnt;

   assign tick = (pre_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - drives 16 outputs low, high or from one shared 8-bit PWM
module pwm_peripheral #(
   parameter int PRESCALE = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   import pwm_pkg::*;

   logic                tick;
   logic                wrap;
   logic                pwm_sig;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty_shadow;
   out_vec_t            en_out;
   out_vec_t            en_pwm;
   out_vec_t            out_next;

   pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
   assign wrap    = tick && (pwm_cnt == DUTY_FULL);
   assign pwm_sig = pwm_level(pwm_cnt, duty_shadow);

   always_comb begin
      out_next = '0;
      for (int i = 0; i < N_OUT; i++) begin
         out_next[i] = !en_out[i] ? 1'b0 : (en_pwm[i] ? pwm_sig : 1'b1);
      end
   end

   // Duty is only sampled at the period boundary so a waveform never glitches mid-period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt      <= '0;
         duty_shadow  <= '0;
         out          <= '0;
         period_start <= 1'b0;
      end else begin
         if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
         end
         if (wrap) begin
            duty_shadow <= pwm_duty_cycle;
         end
         out          <= out_next;
         period_start <= wrap;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - randomized bench against a cycle-index reference model
module tb_pwm_peripheral;

   localparam int PRESCALE = 13;
   localparam int PERIOD   = PRESCALE * 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  en_reg_out_7_0 = '0;
   logic [7:0]  en_reg_out_15_8 = '0;
   logic [7:0]  en_reg_pwm_7_0 = '0;
   logic [7:0]  en_reg_pwm_15_8 = '0;
   logic [7:0]  pwm_duty_cycle = '0;
   logic [15:0] out;
   logic        period_start;

   int          n_vec = 0;
   int          n_err = 0;
   int          c = 0;
   int          shadow = 0;
   logic [15:0] exp_out = '0;
   logic        exp_ps = 1'b0;
   bit          rnd = 1'b0;

   pwm_peripheral #(.PRESCALE(PRESCALE)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out             (out),
      .period_start    (period_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
      end
   endtask

   function automatic logic [7:0] pick_duty();
      case ($urandom_range(0, 5))
         0:       return 8'h00;
         1:       return 8'hFF;
         2:       return 8'h80;
         3:       return 8'h40;
         4:       return 8'hC0;
         default: return 8'($urandom);
      endcase
   endfunction

   // Cycle c (edges since reset release) sits at tick floor(c/13) of the free-running count.
   function automatic logic [15:0] model_out(input int cyc, input int sh,
                                              input logic [15:0] eo, input logic [15:0] ep);
      int   cnt;
      logic lvl;
      logic [15:0] res;
      cnt = (cyc / PRESCALE) % 256;
      lvl = (sh == 255) || (cnt < sh);
      for (int i = 0; i < 16; i++) res[i] = eo[i] && (!ep[i] || lvl);
      return res;
   endfunction

   task automatic step();
      bit last;
      last = (c % PERIOD) == PERIOD - 1;
      if (rnd) begin
         if (last ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 699) == 0))
            pwm_duty_cycle = pick_duty();
         if (last ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 899) == 0)) begin
            {en_reg_out_15_8, en_reg_out_7_0} = 16'($urandom);
            {en_reg_pwm_15_8, en_reg_pwm_7_0} = 16'($urandom);
         end
      end
      exp_out = model_out(c, shadow, {en_reg_out_15_8, en_reg_out_7_0},
                          {en_reg_pwm_15_8, en_reg_pwm_7_0});
      exp_ps  = last;
      if (last) shadow = pwm_duty_cycle;
      c++;
      @(negedge clk);
      check("out", {16'h0, out}, {16'h0, exp_out});
      check("period_start", {31'h0, period_start}, {31'h0, exp_ps});
   endtask

   task automatic release_reset();
      c       = 0;
      shadow  = 0;
      exp_out = '0;
      exp_ps  = 1'b0;
      rst_n   = 1'b1;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("reset_out", {16'h0, out}, 32'h0);
      check("reset_ps", {31'h0, period_start}, 32'h0);
      release_reset();

      rnd = 1'b0;
      repeat (PERIOD + 72) step();

      rnd = 1'b1;
      repeat (4 * PERIOD) step();

      rnd = 1'b0;
      pwm_duty_cycle = 8'h80;
      {en_reg_out_15_8, en_reg_out_7_0} = 16'hFFFF;
      {en_reg_pwm_15_8, en_reg_pwm_7_0} = 16'hFFFF;
      n = (PERIOD - (c % PERIOD)) + 100;
      repeat (n) step();
      check("out_high_before_rst", {16'h0, out}, 32'h0000FFFF);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out", {16'h0, out}, 32'h0);
      check("async_rst_ps", {31'h0, period_start}, 32'h0);
      @(negedge clk);
      check("held_rst_out", {16'h0, out}, 32'h0);
      release_reset();

      rnd = 1'b1;
      repeat (2 * PERIOD) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
